// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank: channel state encoding,
// per-channel register offsets and CTRL bit positions.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pwm_state_e;

    // Register offsets from a channel's base register.
    localparam int CTRL_OFS    = 0;
    localparam int PSC_OFS     = 1;
    localparam int PER_OFS     = 2;
    localparam int DUTY_OFS    = 3;
    localparam int REGS_PER_CH = 4;

    // CTRL register bit positions (bits 7:3 are ignored).
    localparam int EN_BIT      = 0;
    localparam int POL_BIT     = 1;
    localparam int ONESHOT_BIT = 2;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: IDLE/RUN/HOLD FSM, prescaler and period counters,
// and shadow copies of PRESCALE/PERIOD/DUTY/POL that only change at a
// period boundary so a mid-period register write never glitches the output.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic       clk100,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       pol_i,
    input  logic       oneshot_i,
    input  logic [7:0] prescale_i,
    input  logic [7:0] period_i,
    input  logic [7:0] duty_i,
    output logic       pwm_o,
    output logic       period_tick_o,
    output logic       done_o,
    output pwm_state_e state_o
);

    pwm_state_e state_q, state_d;
    logic [7:0] psc_q, psc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] psc_sh_q, psc_sh_d;
    logic [7:0] per_sh_q, per_sh_d;
    logic [7:0] duty_sh_q, duty_sh_d;
    logic       pol_sh_q, pol_sh_d;
    logic       pwm_q, pwm_d;
    logic       tick_q, tick_d;
    logic       done_q, done_d;

    logic       psc_tick;
    logic       wrap;

    assign psc_tick = (psc_q == psc_sh_q);
    assign wrap     = psc_tick && (cnt_q == per_sh_q);

    // Next-state, counter, shadow and output decode for the channel FSM.
    always_comb begin
        state_d   = state_q;
        psc_d     = psc_q;
        cnt_d     = cnt_q;
        psc_sh_d  = psc_sh_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        pol_sh_d  = pol_sh_q;
        pwm_d     = pol_i;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                psc_d = 8'd0;
                cnt_d = 8'd0;
                if (en_i) begin
                    psc_sh_d  = prescale_i;
                    per_sh_d  = period_i;
                    duty_sh_d = duty_i;
                    pol_sh_d  = pol_i;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!en_i) begin
                    // Disable wins over everything, including a wrap this cycle.
                    psc_d   = 8'd0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    pwm_d = (cnt_q < duty_sh_q) ^ pol_sh_q;
                    psc_d = psc_tick ? 8'd0 : psc_q + 8'd1;
                    if (psc_tick) begin
                        cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
                    end
                    if (wrap) begin
                        tick_d    = 1'b1;
                        psc_sh_d  = prescale_i;
                        per_sh_d  = period_i;
                        duty_sh_d = duty_i;
                        pol_sh_d  = pol_i;
                        if (oneshot_i) begin
                            done_d  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                psc_d = 8'd0;
                cnt_d = 8'd0;
                if (en_i) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                psc_d   = 8'd0;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; synchronous active-low reset clears everything.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            psc_q     <= 8'd0;
            cnt_q     <= 8'd0;
            psc_sh_q  <= 8'd0;
            per_sh_q  <= 8'd0;
            duty_sh_q <= 8'd0;
            pol_sh_q  <= 1'b0;
            pwm_q     <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            psc_sh_q  <= psc_sh_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pol_sh_q  <= pol_sh_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign period_tick_o = tick_q;
    assign done_o        = done_q;
    assign state_o       = state_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of NCH independent PWM channels driven from the I2C register file.
// The register bus is registered once here; every channel reads that copy.
// chan_state_o exposes each channel's FSM state (2 bits per channel).
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int REGCOUNT = 20,
    parameter int NCH      = 2,
    parameter int REG_BASE = 8
) (
    input  logic                  clk100,
    input  logic                  reset_n,
    input  logic [8*REGCOUNT-1:0] registers_packed,
    output logic [NCH-1:0]        pwm,
    output logic [NCH-1:0]        period_tick,
    output logic [NCH-1:0]        done,
    output logic [2*NCH-1:0]      chan_state_o
);

    if (REG_BASE + REGS_PER_CH * NCH > REGCOUNT) begin : g_bad_map
        $error("pwm_bank: channel register map runs past REGCOUNT");
    end

    logic [8*REGCOUNT-1:0] regs_q;
    logic                  regs_unused;

    // Only some registers/bits are consumed; fold the whole copy so none dangle.
    assign regs_unused = ^regs_q;

    // Capture the register file every cycle.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= registers_packed;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        localparam int CB = REG_BASE + REGS_PER_CH * n;
        pwm_state_e ch_state;

        pwm_channel u_ch (
            .clk100        (clk100),
            .reset_n       (reset_n),
            .en_i          (regs_q[8*(CB+CTRL_OFS)+EN_BIT]),
            .pol_i         (regs_q[8*(CB+CTRL_OFS)+POL_BIT]),
            .oneshot_i     (regs_q[8*(CB+CTRL_OFS)+ONESHOT_BIT]),
            .prescale_i    (regs_q[8*(CB+PSC_OFS) +: 8]),
            .period_i      (regs_q[8*(CB+PER_OFS) +: 8]),
            .duty_i        (regs_q[8*(CB+DUTY_OFS) +: 8]),
            .pwm_o         (pwm[n]),
            .period_tick_o (period_tick[n]),
            .done_o        (done[n]),
            .state_o       (ch_state)
        );

        assign chan_state_o[2*n +: 2] = ch_state;
    end

endmodule
